// File: rtl/uart_rx_edge_sampler.sv
// UART receive front end: RX_IN synchroniser, per-bit edge counter, frame bit
// counter and a three-point majority sampler around the middle of each bit.
module uart_rx_edge_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_W  = 6,
  parameter int EDGE_W      = 5,
  parameter int BIT_W       = 4
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  counter_en,
  input  logic                  data_samp_en,
  output logic                  rx_sync,
  output logic [EDGE_W-1:0]     edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  localparam int CW = 8;
  localparam logic [BIT_W-1:0] BIT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [EDGE_W-1:0]      edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic                   have_s0_q, have_s0_d;
  logic                   have_s1_q, have_s1_d;
  logic                   hit_sat_q, hit_sat_d;
  logic                   sampled_bit_q, sampled_bit_d;
  logic                   sample_valid_q, sample_valid_d;

  logic [CW-1:0] ps_ext, p_eff, p_last, mid, edge_ext;
  logic          at_last, at_s0, at_s1, at_s2, fire;

  assign rx_sync      = sync_q[SYNC_STAGES-1];
  assign edge_cnt     = edge_cnt_q;
  assign bit_cnt      = bit_cnt_q;
  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;

  // Out-of-range prescale values are clamped into 4..32.
  always_comb begin
    ps_ext = CW'(prescale);
    if (ps_ext < CW'(4))       p_eff = CW'(4);
    else if (ps_ext > CW'(32)) p_eff = CW'(32);
    else                       p_eff = ps_ext;
    p_last   = p_eff - CW'(1);
    mid      = p_eff >> 1;
    edge_ext = CW'(edge_cnt_q);
    at_last  = (edge_ext >= p_last);
    at_s0    = (edge_ext == mid - CW'(1));
    at_s1    = (edge_ext == mid);
    at_s2    = (edge_ext == mid + CW'(1));
  end

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], RX_IN};
  end

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!counter_en) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (at_last) begin
      edge_cnt_d = '0;
      if (bit_cnt_q != BIT_MAX) bit_cnt_d = bit_cnt_q + BIT_W'(1);
    end else begin
      edge_cnt_d = edge_cnt_q + EDGE_W'(1);
    end
  end

  // The third sample is rx_sync itself at mid+1; it goes straight into the vote.
  // hit_sat_q keeps the saturated bit_cnt value from producing a second pulse.
  always_comb begin
    fire = counter_en & data_samp_en & at_s2 & have_s1_q &
           ~((bit_cnt_q == BIT_MAX) & hit_sat_q);
    s0_d           = s0_q;
    s1_d           = s1_q;
    have_s0_d      = have_s0_q;
    have_s1_d      = have_s1_q;
    hit_sat_d      = hit_sat_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    if (!counter_en) begin
      have_s0_d = 1'b0;
      have_s1_d = 1'b0;
      hit_sat_d = 1'b0;
    end else begin
      if (at_s0) begin
        have_s0_d = data_samp_en;
        if (data_samp_en) s0_d = rx_sync;
      end
      if (at_s1) begin
        have_s1_d = data_samp_en & have_s0_q;
        if (data_samp_en) s1_d = rx_sync;
      end
      if (fire) begin
        sampled_bit_d  = (s0_q & s1_q) | (s0_q & rx_sync) | (s1_q & rx_sync);
        sample_valid_d = 1'b1;
        if (bit_cnt_q == BIT_MAX) hit_sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sync_q         <= '1;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      have_s0_q      <= 1'b0;
      have_s1_q      <= 1'b0;
      hit_sat_q      <= 1'b0;
      sampled_bit_q  <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      have_s0_q      <= have_s0_d;
      have_s1_q      <= have_s1_d;
      hit_sat_q      <= hit_sat_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Bench for uart_rx_edge_sampler: directed scenarios plus random frames, all
// checked every cycle against an arithmetic model of counters and votes.
module tb_uart_rx_edge_sampler;

  localparam int SYNC = 2;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RST, RX_IN, counter_en, data_samp_en;
  logic [5:0] prescale;
  logic       rx_sync, sampled_bit, sample_valid;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;

  uart_rx_edge_sampler #(
    .SYNC_STAGES(SYNC), .PRESCALE_W(6), .EDGE_W(5), .BIT_W(4)
  ) dut (
    .clk(clk), .RST(RST), .RX_IN(RX_IN), .prescale(prescale),
    .counter_en(counter_en), .data_samp_en(data_samp_en),
    .rx_sync(rx_sync), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sampled_bit(sampled_bit), .sample_valid(sample_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: n_cnt = number of enabled edges since counter_en rose
  typedef struct { int n; bit sen; bit sync; } log_t;
  log_t log_q[$];
  bit   line_q[$];
  bit   m_sync, m_sbit, m_valid, hit15;
  int   n_cnt, m_edge, m_bitc;

  function automatic int eff_p(input int ps);
    if (ps < 4) return 4;
    if (ps > 32) return 32;
    return ps;
  endfunction

  task automatic model_edge(input bit rst, input bit rx, input bit cen, input bit sen);
    int p, mid, e, b, votes;
    bit cur;
    log_t ent, l1, l2;
    p   = eff_p(int'(prescale));
    mid = p / 2;
    cur = m_sync;
    if (rst) begin
      line_q = {};
      for (int i = 0; i < SYNC; i++) line_q.push_back(1'b1);
      m_sync = 1'b1; n_cnt = 0; log_q.delete();
      m_sbit = 1'b0; m_valid = 1'b0; hit15 = 1'b0;
    end else begin
      void'(line_q.pop_front());
      line_q.push_back(rx);
      m_sync  = line_q[0];
      m_valid = 1'b0;
      if (cen) begin
        e = n_cnt % p;
        b = n_cnt / p;
        if (b > 15) b = 15;
        if (sen && e == mid + 1 && log_q.size() >= 2) begin
          l1 = log_q[log_q.size()-1];
          l2 = log_q[log_q.size()-2];
          if (l1.n == n_cnt - 1 && l2.n == n_cnt - 2 && l1.sen && l2.sen &&
              !(b == 15 && hit15)) begin
            votes   = int'(l1.sync) + int'(l2.sync) + int'(cur);
            m_sbit  = (votes >= 2);
            m_valid = 1'b1;
            if (b == 15) hit15 = 1'b1;
          end
        end
        ent.n = n_cnt; ent.sen = sen; ent.sync = cur;
        log_q.push_back(ent);
        if (log_q.size() > 3) void'(log_q.pop_front());
        n_cnt++;
      end else begin
        n_cnt = 0;
        log_q.delete();
        hit15 = 1'b0;
      end
    end
    m_edge = n_cnt % p;
    m_bitc = n_cnt / p;
    if (m_bitc > 15) m_bitc = 15;
  endtask

  // scoreboard for the directed frame
  logic [0:0] exp_q[$];
  bit sb_on = 1'b0;
  int pulses = 0;
  int max_edge = 0;

  // driver: apply inputs, let the edge happen, check on the falling edge
  task automatic cycle(input bit rst, input bit rx, input bit cen, input bit sen);
    RST = rst; RX_IN = rx; counter_en = cen; data_samp_en = sen;
    @(posedge clk);
    model_edge(rst, rx, cen, sen);
    @(negedge clk);
    check("rx_sync", rx_sync, m_sync);
    check("edge_cnt", edge_cnt, m_edge);
    check("bit_cnt", bit_cnt, m_bitc);
    check("sample_valid", sample_valid, m_valid);
    check("sampled_bit", sampled_bit, m_sbit);
    if (int'(edge_cnt) > max_edge) max_edge = int'(edge_cnt);
    if (sb_on && sample_valid) begin
      pulses++;
      check("frame_pulse_edge", edge_cnt, 10);
      if (exp_q.size() == 0) check("frame_extra_pulse", 1, 0);
      else check("frame_bit", sampled_bit, exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bit fr[10];
    int p;
    bit rx, sen, low;
    RST = 1'b1; RX_IN = 1'b0; counter_en = 1'b0; data_samp_en = 1'b0;
    prescale = 6'd8;
    for (int i = 0; i < SYNC; i++) line_q.push_back(1'b1);
    m_sync = 1'b1; m_sbit = 1'b0; m_valid = 1'b0; hit15 = 1'b0;
    n_cnt = 0; m_edge = 0; m_bitc = 0;
    @(negedge clk);

    // reset with RX_IN low and counter_en high
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("rst_edge", edge_cnt, 0);
    check("rst_sync", rx_sync, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_rel1_sync", rx_sync, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_rel2_sync", rx_sync, 0);
    idle(4);

    // counting at prescale 8
    for (int i = 0; i < 79; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("cnt_last_edge", edge_cnt, 7);
    check("cnt_last_bit", bit_cnt, 9);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("cnt_clear_edge", edge_cnt, 0);
    check("cnt_clear_bit", bit_cnt, 0);

    // frame 0xA5, LSB first, start 0, stop 1
    prescale = 6'd16;
    idle(4);
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[i+1] = (((8'hA5) >> i) & 1) != 0;
    fr[9] = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(fr[i]);
    sb_on = 1'b1; pulses = 0;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 16; j++) cycle(1'b0, fr[k], 1'b1, 1'b1);
    sb_on = 1'b0;
    check("frame_pulses", pulses, 10);
    check("frame_left", exp_q.size(), 0);
    idle(2);

    // glitch vote at prescale 8 (rx_sync lags RX_IN by two cycles)
    prescale = 6'd8;
    for (int v = 0; v < 2; v++) begin
      idle(4);
      for (int i = 0; i < 16; i++) begin
        low = (i + 2 >= 8) && (i + 2 < 16) &&
              (((i + 2) % 8 == 4) || (v == 1 && (i + 2) % 8 == 3));
        cycle(1'b0, !low, 1'b1, 1'b1);
      end
      check($sformatf("glitch_vote%0d", v), sampled_bit, (v == 0) ? 1 : 0);
    end
    idle(2);

    // prescale below range clamps to 4
    prescale = 6'd2;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    check("p2_wrap_edge", edge_cnt, 0);
    check("p2_wrap_bit", bit_cnt, 1);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    idle(1);

    // prescale 32 reaches edge 31
    prescale = 6'd32;
    max_edge = 0;
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("p32_max_edge", max_edge, 31);
    idle(1);

    // counter_en falls on the wrap cycle
    prescale = 6'd8;
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("wrapclr_pre_edge", edge_cnt, 7);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("wrapclr_bit", bit_cnt, 0);
    check("wrapclr_edge", edge_cnt, 0);

    // saturation after 20 bits at prescale 4
    prescale = 6'd4;
    for (int i = 0; i < 82; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    check("sat_bit", bit_cnt, 15);
    idle(2);

    // mid-frame abort at bit 3, edge 5
    prescale = 6'd8;
    for (int i = 0; i < 29; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("abort_pre_bit", bit_cnt, 3);
    check("abort_pre_edge", edge_cnt, 5);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check("abort_bit", bit_cnt, 0);
    check("abort_edge", edge_cnt, 0);
    check("abort_valid", sample_valid, 0);
    check("abort_sbit", sampled_bit, 0);
    check("abort_sync", rx_sync, 1);
    idle(3);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("abort_new_bit", bit_cnt, 1);
    idle(2);

    // random frames
    for (int r = 0; r < 30; r++) begin
      prescale = 6'($urandom_range(0, 40));
      p = eff_p(int'(prescale));
      idle($urandom_range(1, 4));
      for (int k = 0; k < int'($urandom_range(1, 18)); k++) begin
        bit v;
        v = 1'($urandom_range(0, 1));
        for (int j = 0; j < p; j++) begin
          rx  = v ^ ($urandom_range(0, 7) == 0);
          sen = ($urandom_range(0, 15) != 0);
          cycle($urandom_range(0, 399) == 0, rx, $urandom_range(0, 199) != 0, sen);
        end
      end
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
